// File: rtl/conv_operand_loader.sv
// Byte-stream to packed FILTER/DATA operand loader for the convolution engine.
// Optional trailing checksum byte per frame: define CONV_LOADER_CHECKSUM_EN.
module conv_operand_loader #(
  parameter int unsigned BW           = 8,
  parameter int unsigned FILTER_BYTES = 9,
  parameter int unsigned DATA_BYTES   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic [BW-1:0]                in_byte,
  output logic                         in_ready,
  output logic [FILTER_BYTES*BW-1:0]   FILTER,
  output logic [DATA_BYTES*BW-1:0]     DATA,
  output logic                         op_valid,
  input  logic                         op_ready,
  input  logic                         err_clr,
  output logic                         err,
  output logic [7:0]                   frames_done,
  output logic [2:0]                   state
);

`ifdef CONV_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadF = 3'd1,
    StLoadD = 3'd2,
    StHold  = 3'd3,
    StLoadC = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadF = 3'd1,
    StLoadD = 3'd2,
    StHold  = 3'd3
  } state_e;
`endif

  state_e                       r_state;
  state_e                       w_state_d;
  logic [4:0]                   r_cnt;
  logic [4:0]                   w_cnt_d;
  logic [FILTER_BYTES*BW-1:0]   r_filter;
  logic [DATA_BYTES*BW-1:0]     r_data;
  logic                         r_op_valid;
  logic                         w_op_valid_d;
  logic                         r_err;
  logic [7:0]                   r_frames;

  logic                         w_xfer;
  logic                         w_err_set;
  logic                         w_fwr;
  logic                         w_dwr;
  logic [4:0]                   w_widx;
  logic                         w_frame_done;

`ifdef CONV_LOADER_CHECKSUM_EN
  logic [BW-1:0]                r_sum;
`endif

  assign in_ready    = (r_state != StHold);
  assign w_xfer      = in_valid & in_ready;
  assign FILTER      = r_filter;
  assign DATA        = r_data;
  assign op_valid    = r_op_valid;
  assign err         = r_err;
  assign frames_done = r_frames;
  assign state       = r_state;

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_op_valid_d = r_op_valid;
    w_err_set    = 1'b0;
    w_fwr        = 1'b0;
    w_dwr        = 1'b0;
    w_widx       = r_cnt;
    w_frame_done = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_xfer) begin
          if (in_first) begin
            w_fwr     = 1'b1;
            w_widx    = 5'd0;
            w_cnt_d   = 5'd1;
            w_state_d = StLoadF;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end

      StHold: begin
        if (r_op_valid && op_ready) begin
          w_op_valid_d = 1'b0;
          w_frame_done = 1'b1;
          w_state_d    = StIdle;
        end
      end

      default: begin
        // Any in_first byte inside a frame restarts it as filter element 0.
        if (w_xfer && in_first) begin
          w_err_set = 1'b1;
          w_fwr     = 1'b1;
          w_widx    = 5'd0;
          w_cnt_d   = 5'd1;
          w_state_d = StLoadF;
        end else if (w_xfer) begin
          if (r_state == StLoadF) begin
            w_fwr = 1'b1;
            if (r_cnt == 5'(FILTER_BYTES - 1)) begin
              w_cnt_d   = 5'd0;
              w_state_d = StLoadD;
            end else begin
              w_cnt_d = r_cnt + 5'd1;
            end
          end else if (r_state == StLoadD) begin
            w_dwr = 1'b1;
            if (r_cnt == 5'(DATA_BYTES - 1)) begin
              w_cnt_d = 5'd0;
`ifdef CONV_LOADER_CHECKSUM_EN
              w_state_d = StLoadC;
`else
              w_state_d    = StHold;
              w_op_valid_d = 1'b1;
`endif
            end else begin
              w_cnt_d = r_cnt + 5'd1;
            end
          end
`ifdef CONV_LOADER_CHECKSUM_EN
          else if (r_state == StLoadC) begin
            if (in_byte == r_sum) begin
              w_state_d    = StHold;
              w_op_valid_d = 1'b1;
            end else begin
              w_err_set = 1'b1;
              w_state_d = StIdle;
            end
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= 5'd0;
      r_filter   <= '0;
      r_data     <= '0;
      r_op_valid <= 1'b0;
      r_err      <= 1'b0;
      r_frames   <= 8'd0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_op_valid <= w_op_valid_d;
      // A new error event takes priority over a simultaneous clear.
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
      if (w_frame_done) begin
        r_frames <= r_frames + 8'd1;
      end
      for (int unsigned k = 0; k < FILTER_BYTES; k++) begin
        if (w_fwr && (w_widx == 5'(k))) begin
          r_filter[k*BW +: BW] <= in_byte;
        end
      end
      for (int unsigned k = 0; k < DATA_BYTES; k++) begin
        if (w_dwr && (w_widx == 5'(k))) begin
          r_data[k*BW +: BW] <= in_byte;
        end
      end
    end
  end

`ifdef CONV_LOADER_CHECKSUM_EN
  // Running sum of accepted frame bytes; an in_first byte seeds it afresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
    end else if (w_fwr || w_dwr) begin
      r_sum <= in_first ? in_byte : r_sum + in_byte;
    end
  end
`endif

endmodule

// File: tb/tb_conv_operand_loader.sv
// Scoreboard bench for conv_operand_loader; honours CONV_LOADER_CHECKSUM_EN.
module tb_conv_operand_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_first;
  logic [7:0]   in_byte;
  logic         in_ready;
  logic [71:0]  FILTER;
  logic [127:0] DATA;
  logic         op_valid;
  logic         op_ready;
  logic         err_clr;
  logic         err;
  logic [7:0]   frames_done;
  logic [2:0]   state;

  conv_operand_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_first    (in_first),
    .in_byte     (in_byte),
    .in_ready    (in_ready),
    .FILTER      (FILTER),
    .DATA        (DATA),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .err_clr     (err_clr),
    .err         (err),
    .frames_done (frames_done),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [71:0]  f;
    logic [127:0] d;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_frames = 8'd0;
  logic       prev_valid = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: each rising op_valid must match the oldest queued frame.
  always @(negedge clk) begin
    exp_t e;
    if (op_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_op_valid: got op_valid=1, expected no frame");
      end else begin
        e = sb_q.pop_front();
        check("op_filter", 128'(FILTER), 128'(e.f));
        check("op_data", DATA, e.d);
      end
    end
    prev_valid = op_valid;
  end

  function automatic logic [7:0] frame_byte(input logic [71:0] f, input logic [127:0] d,
                                            input int idx);
    if (idx < 9) return f[8*idx +: 8];
    return d[8*(idx-9) +: 8];
  endfunction

  function automatic logic [7:0] frame_sum(input logic [71:0] f, input logic [127:0] d);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < 25; i++) s = s + frame_byte(f, d, i);
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic first, input int gap);
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_in_ready: got in_ready=0, expected 1");
    end
    in_valid = 1'b1;
    in_first = first;
    in_byte  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_range(input logic [71:0] f, input logic [127:0] d, input int lo,
                            input int hi, input int gap);
    for (int i = lo; i < hi; i++) begin
      send_byte(frame_byte(f, d, i), i == 0, (i == 4 || i == 15) ? gap : 0);
    end
  endtask

  task automatic send_tail(input logic [71:0] f, input logic [127:0] d);
`ifdef CONV_LOADER_CHECKSUM_EN
    send_byte(frame_sum(f, d), 1'b0, 0);
`else
    if (f === 72'hx && d === 128'hx) $display("unreachable");
`endif
  endtask

  task automatic send_frame(input logic [71:0] f, input logic [127:0] d, input int gap);
    send_range(f, d, 0, 25, gap);
    send_tail(f, d);
  endtask

  task automatic accept();
    int k = 0;
    while (!op_valid && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("wait_op_valid", 128'(op_valid), 128'(1'b1));
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    op_ready = 1'b0;
    exp_frames = exp_frames + 8'd1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    logic [71:0]  fa, fb, fc, fn;
    logic [127:0] da, db, dc, dn;
    exp_t         e;

    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_byte = 8'h00;
    op_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_state", 128'(state), 128'(3'd0));
    check("rst_filter", 128'(FILTER), 128'd0);
    check("rst_data", DATA, 128'd0);
    check("rst_op_valid", 128'(op_valid), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_frames", 128'(frames_done), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);

    // Frame A: hold with op_ready low, then accept after 3 cycles.
    fa = 72'h090807060504030201;
    da = 128'h1F1E1D1C1B1A19181716151413121110;
    e.f = fa; e.d = da; sb_q.push_back(e);
    send_frame(fa, da, 0);
    check("a_op_valid_lat", 128'(op_valid), 128'd1);
    check("a_in_ready_hold", 128'(in_ready), 128'd0);
    check("a_state_hold", 128'(state), 128'(3'd3));
    repeat (3) @(posedge clk);
    #1;
    check("a_held_valid", 128'(op_valid), 128'd1);
    check("a_held_filter", 128'(FILTER), 128'(72'h090807060504030201));
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    op_ready = 1'b0;
    exp_frames = exp_frames + 8'd1;
    check("a_op_valid_drop", 128'(op_valid), 128'd0);
    check("a_frames", 128'(frames_done), 128'(exp_frames));
    check("a_state_idle", 128'(state), 128'(3'd0));
    check("a_in_ready", 128'(in_ready), 128'd1);

    // op_ready outside HOLD has no effect.
    op_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    op_ready = 1'b0;
    check("idle_op_ready", 128'(frames_done), 128'(exp_frames));

    // Stray byte in IDLE; err_clr; set beats clear.
    send_byte(8'h55, 1'b0, 0);
    check("stray_err", 128'(err), 128'd1);
    check("stray_state", 128'(state), 128'(3'd0));
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_clr", 128'(err), 128'd0);
    err_clr = 1'b1;
    send_byte(8'h66, 1'b0, 0);
    err_clr = 1'b0;
    check("err_set_wins", 128'(err), 128'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_clr2", 128'(err), 128'd0);

    // Resync at data element 4, then full frame C with bubbles.
    fb = 72'hA8A7A6A5A4A3A2A1A0;
    db = 128'hBFBEBDBCBBBAB9B8B7B6B5B4B3B2B1B0;
    fc = 72'h484746454443424140;
    dc = 128'h5F5E5D5C5B5A59585756555453525150;
    send_range(fb, db, 0, 13, 0);
    check("b_state_load_d", 128'(state), 128'(3'd2));
    e.f = fc; e.d = dc; sb_q.push_back(e);
    send_range(fc, dc, 0, 1, 0);
    check("resync_err", 128'(err), 128'd1);
    check("resync_state", 128'(state), 128'(3'd1));
    send_range(fc, dc, 1, 24, 2);
    check("c_no_early_valid", 128'(op_valid), 128'd0);
    send_range(fc, dc, 24, 25, 0);
    send_tail(fc, dc);
    accept();
    check("c_frames", 128'(frames_done), 128'(exp_frames));
    check("c_err_sticky", 128'(err), 128'd1);

    // Asynchronous reset mid LOAD_D.
    send_range(fa, da, 0, 12, 0);
    #1;
    rst = 1'b1;
    #1;
    check("arst_state", 128'(state), 128'(3'd0));
    check("arst_filter", 128'(FILTER), 128'd0);
    check("arst_data", DATA, 128'd0);
    check("arst_err", 128'(err), 128'd0);
    check("arst_frames", 128'(frames_done), 128'd0);
    check("arst_op_valid", 128'(op_valid), 128'd0);
    exp_frames = 8'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 256 back-to-back frames: counter wraps.
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < 9; i++) fn[8*i +: 8] = 8'(n + i);
      for (int j = 0; j < 16; j++) dn[8*j +: 8] = 8'(n * 3 + j + 100);
      e.f = fn; e.d = dn; sb_q.push_back(e);
      send_frame(fn, dn, 0);
      accept();
      if (n == 254) check("frames_255", 128'(frames_done), 128'(8'd255));
    end
    check("frames_wrap", 128'(frames_done), 128'(exp_frames));
    check("frames_wrap_zero", 128'(frames_done), 128'd0);

`ifdef CONV_LOADER_CHECKSUM_EN
    fn = 72'h090807060504030201;
    dn = 128'h191817161514131211100F0E0D0C0B0A;
    e.f = fn; e.d = dn; sb_q.push_back(e);
    send_range(fn, dn, 0, 25, 0);
    check("ck_load_c", 128'(state), 128'(3'd4));
    send_byte(8'h45, 1'b0, 0);
    check("ck_good_valid", 128'(op_valid), 128'd1);
    check("ck_good_state", 128'(state), 128'(3'd3));
    accept();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    send_range(fn, dn, 0, 25, 0);
    send_byte(8'h44, 1'b0, 0);
    check("ck_bad_err", 128'(err), 128'd1);
    check("ck_bad_valid", 128'(op_valid), 128'd0);
    check("ck_bad_state", 128'(state), 128'(3'd0));
    check("ck_bad_frames", 128'(frames_done), 128'(exp_frames));
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 128'(sb_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
